// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM-style memory bus between the fetch-stage
// instruction port and the mem-stage data port, one transaction at a time.
// Each transaction runs IDLE -> GRANT -> RESP. Contention between the two
// ports is settled round-robin. A transaction that waits too long for
// mem_ready is aborted with err.
//
// Handshake: a port raises *_req and holds it, with its address and data
// stable, until its *_ok pulse. The *_ok pulse lasts one cycle and is the
// only completion indication. On the bus, mem_req stays high until the
// memory answers with mem_ready or the transaction times out. mem_ready is
// ignored whenever no transaction is in GRANT.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ok,
  output logic        inst_stall,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ok,
  output logic        data_stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } stateT;

  stateT       state;
  stateT       nextState;
  logic        lastData;   // 1 when the data port was granted most recently
  logic        grantData;  // 1 when the current transaction belongs to the data port
  logic [7:0]  waitCnt;
  logic        anyReq;
  logic        winData;
  logic        timeoutHit;

  assign anyReq     = inst_req | data_req;
  // The data port wins when it is alone, or when both ask and inst went last.
  assign winData    = data_req & (~inst_req | ~lastData);
  assign timeoutHit = (waitCnt == 8'(TIMEOUT - 1)) & ~mem_ready;

  assign inst_stall = inst_req & ~inst_ok;
  assign data_stall = data_req & ~data_ok;
  assign dbgState   = state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = GRANT;
      GRANT:   if (mem_ready || timeoutHit) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Bus registers, grant bookkeeping, read-data capture and completion pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastData   <= 1'b0;
      grantData  <= 1'b0;
      waitCnt    <= 8'd0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wen    <= 4'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
      inst_ok    <= 1'b0;
      data_ok    <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Completion pulses are only ever set for the single RESP cycle.
      inst_ok <= 1'b0;
      data_ok <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            grantData <= winData;
            lastData  <= winData;
            waitCnt   <= 8'd0;
            mem_req   <= 1'b1;
            if (winData) begin
              mem_wr    <= data_wr;
              mem_wen   <= data_wr ? data_wen : 4'd0;
              mem_addr  <= data_addr;
              mem_wdata <= data_wdata;
            end else begin
              mem_wr    <= 1'b0;
              mem_wen   <= 4'd0;
              mem_addr  <= inst_addr;
              mem_wdata <= 32'd0;
            end
          end
        end
        GRANT: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_wr  <= 1'b0;
            mem_wen <= 4'd0;
            if (grantData) begin
              data_ok <= 1'b1;
              // Writes return nothing, so the last load word stays visible.
              if (!mem_wr) data_rdata <= mem_rdata;
            end else begin
              inst_ok    <= 1'b1;
              inst_rdata <= mem_rdata;
            end
          end else if (timeoutHit) begin
            // Abort: the port still completes, but with err and a zero word.
            mem_req <= 1'b0;
            mem_wr  <= 1'b0;
            mem_wen <= 4'd0;
            err     <= 1'b1;
            if (grantData) begin
              data_ok    <= 1'b1;
              data_rdata <= 32'd0;
            end else begin
              inst_ok    <= 1'b1;
              inst_rdata <= 32'd0;
            end
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        default: begin
          // RESP: requests are ignored; the requester advances on this edge.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Outputs are sampled on the falling
// edge, and inputs are driven at the same moment. Expected completions
// ({port is data, rdata}) are queued when a request is driven and popped
// when the matching ok pulse appears.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ok;
  logic        inst_stall;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        data_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        err;
  logic [1:0]  dbgState;

  int          tests = 0;
  int          fails = 0;
  logic [32:0] expQ[$];
  logic [32:0] expItem;
  logic [31:0] expDataRdata;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_ok(inst_ok), .inst_stall(inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_ok(data_ok), .data_stall(data_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err), .dbgState(dbgState)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    inst_req = 1'b0; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_wen = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0;
    mem_rdata = 32'd0; mem_ready = 1'b0;
  endtask

  function automatic logic [31:0] memModel(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    inst_req = 1'b1;
    #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    tests++; if ({inst_ok, data_ok, err} !== 3'b000) begin fails++; $display("FAIL rst_ok_err: got %b want 000", {inst_ok, data_ok, err}); end
    tests++; if ({inst_rdata, data_rdata} !== 64'd0) begin fails++; $display("FAIL rst_rdata: got %h want 0", {inst_rdata, data_rdata}); end
    tests++; if (dbgState !== 2'd0) begin fails++; $display("FAIL rst_state: got %0d want 0", dbgState); end
    tests++; if (inst_stall !== 1'b1) begin fails++; $display("FAIL rst_inst_stall: got %b want 1", inst_stall); end
    inst_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    expDataRdata = 32'd0;
  endtask

  task automatic test_inst_read();
    inst_addr = 32'hBFC0_0000; inst_req = 1'b1;
    expQ.push_back({1'b0, 32'h3C01_0001});
    #1;
    tests++; if (inst_stall !== 1'b1) begin fails++; $display("FAIL ird_stall_c0: got %b want 1", inst_stall); end
    tick();  // cycle 1
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL ird_mem_req_c1: got %b want 1", mem_req); end
    tests++; if (mem_addr !== 32'hBFC0_0000) begin fails++; $display("FAIL ird_addr: got %h want bfc00000", mem_addr); end
    tests++; if ({mem_wr, mem_wen} !== 5'd0) begin fails++; $display("FAIL ird_wr_wen: got %b want 0", {mem_wr, mem_wen}); end
    tests++; if (inst_stall !== 1'b1) begin fails++; $display("FAIL ird_stall_c1: got %b want 1", inst_stall); end
    mem_ready = 1'b1; mem_rdata = 32'h3C01_0001;
    tick();  // cycle 2
    mem_ready = 1'b0; mem_rdata = 32'd0;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL ird_mem_req_c2: got %b want 0", mem_req); end
    tests++; if ({inst_ok, data_ok, err} !== 3'b100) begin fails++; $display("FAIL ird_ok_c2: got %b want 100", {inst_ok, data_ok, err}); end
    tests++; if (inst_stall !== 1'b0) begin fails++; $display("FAIL ird_stall_c2: got %b want 0", inst_stall); end
    tests++;
    if (expQ.size() == 0) begin fails++; $display("FAIL ird_sb: got ok want none queued"); end
    else begin
      expItem = expQ.pop_front();
      if ({1'b0, inst_rdata} !== expItem) begin fails++; $display("FAIL ird_sb: got %h want %h", {1'b0, inst_rdata}, expItem); end
    end
    inst_req = 1'b0;
    tick();  // cycle 3
    tests++; if (inst_ok !== 1'b0 || dbgState !== 2'd0) begin fails++; $display("FAIL ird_idle_c3: got ok=%b st=%0d want 0/0", inst_ok, dbgState); end
  endtask

  task automatic test_data_write();
    data_req = 1'b1; data_wr = 1'b1; data_wen = 4'b0011;
    data_addr = 32'h10; data_wdata = 32'hAABB_CCDD;
    expQ.push_back({1'b1, expDataRdata});
    #1;
    tests++; if (data_stall !== 1'b1) begin fails++; $display("FAIL wr_stall_c0: got %b want 1", data_stall); end
    for (int cyc = 1; cyc <= 3; cyc++) begin
      tick();
      tests++;
      if ({mem_req, mem_wr, mem_wen, data_ok} !== 7'b1100110 || mem_addr !== 32'h10 || mem_wdata !== 32'hAABB_CCDD) begin
        fails++;
        $display("FAIL wr_bus_c%0d: got req=%b wr=%b wen=%b ok=%b addr=%h wd=%h want 1 1 0011 0 00000010 aabbccdd",
                 cyc, mem_req, mem_wr, mem_wen, data_ok, mem_addr, mem_wdata);
      end
      if (cyc == 3) begin mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
    end
    tick();  // cycle 4
    mem_ready = 1'b0; mem_rdata = 32'd0;
    tests++; if ({data_ok, inst_ok, err} !== 3'b100) begin fails++; $display("FAIL wr_ok_c4: got %b want 100", {data_ok, inst_ok, err}); end
    tests++; if ({mem_req, mem_wr, mem_wen} !== 6'd0) begin fails++; $display("FAIL wr_bus_clear: got %b want 0", {mem_req, mem_wr, mem_wen}); end
    tests++;
    if (expQ.size() == 0) begin fails++; $display("FAIL wr_sb: got ok want none queued"); end
    else begin
      expItem = expQ.pop_front();
      if ({1'b1, data_rdata} !== expItem) begin fails++; $display("FAIL wr_sb: got %h want %h", {1'b1, data_rdata}, expItem); end
    end
    clearInputs();
    tick();
  endtask

  task automatic test_read_wen();
    data_req = 1'b1; data_wr = 1'b0; data_wen = 4'b1111; data_addr = 32'h44;
    expQ.push_back({1'b1, 32'h1234_5678});
    tick();  // cycle 1
    tests++; if ({mem_req, mem_wr, mem_wen} !== 6'b100000) begin fails++; $display("FAIL rdwen_bus: got %b want 100000", {mem_req, mem_wr, mem_wen}); end
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();  // cycle 2
    mem_ready = 1'b0; mem_rdata = 32'd0;
    tests++; if (data_ok !== 1'b1) begin fails++; $display("FAIL rdwen_ok: got %b want 1", data_ok); end
    tests++;
    if (expQ.size() == 0) begin fails++; $display("FAIL rdwen_sb: got ok want none queued"); end
    else begin
      expItem = expQ.pop_front();
      if ({1'b1, data_rdata} !== expItem) begin fails++; $display("FAIL rdwen_sb: got %h want %h", {1'b1, data_rdata}, expItem); end
    end
    expDataRdata = 32'h1234_5678;
    clearInputs();
    tick();
  endtask

  task automatic test_back_to_back();
    int served;
    int prevOk;
    logic isData;
    rst = 1'b0; tick(); rst = 1'b1; tick();
    served = 0; prevOk = 0;
    inst_addr = 32'h100; data_addr = 32'h200; data_wr = 1'b0;
    inst_req = 1'b1; data_req = 1'b1;
    expQ.push_back({1'b1, memModel(32'h200)});
    expQ.push_back({1'b0, memModel(32'h100)});
    expQ.push_back({1'b1, memModel(32'h200)});
    expQ.push_back({1'b0, memModel(32'h100)});
    for (int cyc = 1; cyc <= 30 && served < 4; cyc++) begin
      tick();
      mem_ready = 1'b0;
      if (inst_ok || data_ok) begin
        isData = data_ok;
        tests++; if ((inst_ok & data_ok) || err) begin fails++; $display("FAIL b2b_ok_pair: got inst=%b data=%b err=%b want one ok, no err", inst_ok, data_ok, err); end
        tests++;
        if (expQ.size() == 0) begin fails++; $display("FAIL b2b_sb: got ok want none queued"); end
        else begin
          expItem = expQ.pop_front();
          if ({isData, isData ? data_rdata : inst_rdata} !== expItem) begin
            fails++; $display("FAIL b2b_sb%0d: got %h want %h", served, {isData, isData ? data_rdata : inst_rdata}, expItem);
          end
        end
        if (served > 0) begin
          tests++; if (cyc - prevOk != 3) begin fails++; $display("FAIL b2b_gap%0d: got %0d want 3", served, cyc - prevOk); end
        end
        prevOk = cyc;
        served++;
        if (served == 4) begin inst_req = 1'b0; data_req = 1'b0; end
      end
      if (mem_req) begin
        mem_ready = 1'b1; mem_rdata = memModel(mem_addr);
      end
    end
    tests++; if (served != 4) begin fails++; $display("FAIL b2b_count: got %0d want 4", served); end
    clearInputs();
    tick();
    expDataRdata = memModel(32'h200);
  endtask

  task automatic test_timeout();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h300;
    expQ.push_back({1'b1, 32'd0});
    for (int cyc = 1; cyc <= TO; cyc++) begin
      tick();
      tests++; if ({mem_req, data_ok, err} !== 3'b100) begin fails++; $display("FAIL to_wait_c%0d: got %b want 100", cyc, {mem_req, data_ok, err}); end
    end
    tick();  // cycle TO+1
    tests++; if ({mem_req, data_ok, err} !== 3'b011) begin fails++; $display("FAIL to_done: got %b want 011", {mem_req, data_ok, err}); end
    tests++;
    if (expQ.size() == 0) begin fails++; $display("FAIL to_sb: got ok want none queued"); end
    else begin
      expItem = expQ.pop_front();
      if ({1'b1, data_rdata} !== expItem) begin fails++; $display("FAIL to_sb: got %h want %h", {1'b1, data_rdata}, expItem); end
    end
    data_req = 1'b0;
    tick();
    tests++; if ({err, data_ok} !== 2'b00) begin fails++; $display("FAIL to_after: got %b want 00", {err, data_ok}); end
  endtask

  task automatic test_reset_mid_grant();
    inst_req = 1'b1; inst_addr = 32'h400;
    tick();  // cycle 1
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rmg_c1: got %b want 1", mem_req); end
    tick();  // cycle 2, second GRANT cycle
    rst = 1'b0;
    #1;
    tests++; if ({mem_req, inst_ok, err} !== 3'b000 || dbgState !== 2'd0) begin fails++; $display("FAIL rmg_drop: got %b st=%0d want 000 st=0", {mem_req, inst_ok, err}, dbgState); end
    tests++; if ({inst_rdata, data_rdata} !== 64'd0 || inst_stall !== 1'b1) begin fails++; $display("FAIL rmg_regs: got %h stall=%b want 0 stall=1", {inst_rdata, data_rdata}, inst_stall); end
    tick();
    rst = 1'b1;
    tests++; if (inst_ok !== 1'b0) begin fails++; $display("FAIL rmg_no_ok: got %b want 0", inst_ok); end
    tick();  // IDLE sampled the held request on the last edge
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h400 || inst_ok !== 1'b0) begin fails++; $display("FAIL rmg_reissue: got req=%b addr=%h ok=%b want 1 400 0", mem_req, mem_addr, inst_ok); end
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    expQ.push_back({1'b0, 32'h0BAD_F00D});
    tick();
    mem_ready = 1'b0; mem_rdata = 32'd0;
    tests++; if (inst_ok !== 1'b1) begin fails++; $display("FAIL rmg_ok: got %b want 1", inst_ok); end
    tests++;
    if (expQ.size() == 0) begin fails++; $display("FAIL rmg_sb: got ok want none queued"); end
    else begin
      expItem = expQ.pop_front();
      if ({1'b0, inst_rdata} !== expItem) begin fails++; $display("FAIL rmg_sb: got %h want %h", {1'b0, inst_rdata}, expItem); end
    end
    inst_req = 1'b0;
    tick();
  endtask

  initial begin
    clearInputs();
    rst = 1'b0;
    expDataRdata = 32'd0;
    repeat (2) tick();
    test_reset();
    test_inst_read();
    test_data_write();
    test_read_wen();
    test_back_to_back();
    test_timeout();
    test_reset_mid_grant();
    tests++; if (expQ.size() != 0) begin fails++; $display("FAIL sb_drain: got %0d left want 0", expQ.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter sitting between the pipelined MIPS datapath and a single shared SRAM-style memory bus. It serves the fetch-stage instruction port and the mem-stage data port, one transaction at a time. It registers the winning request onto the bus, waits for the memory handshake, and returns read data with a one-cycle completion pulse. The per-port stall outputs feed the hazard unit: `inst_stall` drives the fetch stall and `data_stall` drives the memory stall.

## Interface
- `TIMEOUT`, 16: maximum GRANT cycles without `mem_ready` before the transaction is aborted (range 2..255).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `inst_req`  in  1  instruction read request; held with `inst_addr` stable until `inst_ok`.
- `inst_addr`  in  32  instruction byte address.
- `inst_rdata`  out  32  instruction word; valid in the `inst_ok` cycle, held until the next instruction completion.
- `inst_ok`  out  1  one-cycle completion pulse.
- `inst_stall`  out  1  `inst_req & ~inst_ok`.
- `data_req`  in  1  data request; held with the other `data_*` inputs stable until `data_ok`.
- `data_wr`  in  1  1 = write, 0 = read.
- `data_wen`  in  4  byte enables, used for writes only.
- `data_addr`  in  32  data byte address.
- `data_wdata`  in  32  store data.
- `data_rdata`  out  32  load word; valid in the `data_ok` cycle, held afterwards.
- `data_ok`  out  1  one-cycle completion pulse.
- `data_stall`  out  1  `data_req & ~data_ok`.
- `mem_req`  out  1  bus request; held until `mem_ready` or timeout.
- `mem_wr`  out  1  bus write.
- `mem_wen`  out  4  bus byte enables; forced to 0 when `mem_wr` = 0.
- `mem_addr`  out  32  bus address.
- `mem_wdata`  out  32  bus write data.
- `mem_rdata`  in  32  read data; sampled on the edge where `mem_ready` = 1.
- `mem_ready`  in  1  memory completion; only meaningful while `mem_req` = 1.
- `err`  out  1  pulses with `ok` when a transaction timed out.

## Operation
- States:
  - IDLE: no transaction; samples requests.
  - GRANT: `mem_req` = 1; waits for `mem_ready`.
  - RESP: `inst_ok` or `data_ok` asserted for one cycle.
- Selection in IDLE:
  - Only one port requesting: that port wins.
  - Both ports requesting: round-robin. The port not served last wins.
  - `last` resets to INST, so the first contention goes to data.
  - `last` updates on every transition into GRANT.
- IDLE -> GRANT when any request is present. On that edge the arbiter registers:
  - `mem_addr`, `mem_wr`, `mem_wen`, `mem_wdata` from the winner. Instruction transactions are reads with `mem_wen` = 0.
  - `mem_req` = 1.
  - The grant id.
  - Wait counter cleared to 0.
- GRANT -> RESP on `mem_ready` = 1. On that edge:
  - `mem_rdata` is captured into the winner's rdata register; writes leave rdata unchanged.
  - `mem_req`, `mem_wr` and `mem_wen` clear.
- GRANT timeout: the wait counter increments each GRANT cycle without `mem_ready`. When it equals `TIMEOUT` - 1 and `mem_ready` = 0:
  - Go to RESP with `err` = 1.
  - The winner's rdata is forced to 0.
  - `mem_req` clears.
- RESP -> IDLE unconditionally. `ok` is asserted for the granted port only. Requests are ignored in RESP, because the requester sees `ok` and advances on that edge.
- Unserved port: it keeps requesting, its stall stays high, and it is arbitrated in the next IDLE cycle.
- Write with `data_wen` = 0: a full transaction that completes normally.
- Reset (`rst` = 0, any time, including mid-GRANT):
  - State goes to IDLE and `last` to INST.
  - All outputs go to 0: `mem_*`, `ok`, `err`, both rdata registers.
  - Stalls follow their equations.
  - An interrupted transaction never signals `ok`.

## Timing
- Request sampled in IDLE at cycle 0. `mem_req` is high from cycle 1. `mem_ready` arrives in cycle 1+w (w ≥ 0 wait cycles). `ok` is in cycle 2+w. IDLE is in cycle 3+w.
- Zero-wait memory gives 3 cycles per transaction. Back-to-back requests from either port therefore issue every 3+w cycles.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, then `ok` and `err` assert in the next cycle.
- All bus outputs and `ok`/`err` are registered. Only the stalls are combinational.
- `mem_ready` sampled outside GRANT is ignored.

## Test plan
- Reset, then `inst_req` with `inst_addr` = 0xBFC00000 and memory returning 0x3C010001 with w = 0:
  - `mem_req` is high in cycle 1 only.
  - `inst_ok` and `inst_rdata` = 0x3C010001 in cycle 2.
  - `inst_stall` is high in cycles 0–1.
- Data write with `data_addr` = 0x10, `data_wen` = 4'b0011, `data_wdata` = 0xAABBCCDD, w = 2:
  - `mem_wr` = 1, `mem_wen` = 0011 for cycles 1–3.
  - `data_ok` in cycle 4.
  - `data_rdata` unchanged.
- Both ports requesting continuously after reset: grant order is data, inst, data, inst. Each `ok` arrives 3 cycles after the previous one.
- Data read with `mem_ready` never asserted and `TIMEOUT` = 4:
  - `mem_req` is high for cycles 1–4.
  - `data_ok` = 1, `err` = 1, `data_rdata` = 0 in cycle 5.
- `rst` asserted in the second GRANT cycle of an instruction read:
  - `mem_req` drops immediately and no `inst_ok` is issued.
  - After release, the still-held `inst_req` is re-issued starting from IDLE.
- Data read with `mem_wr` = 0 but `data_wen` = 4'b1111: `mem_wen` = 0 on the bus.
